// File: rtl/cfg_serial_loader.sv
// Serial (cs_n/sclk/sdi) to parallel loader for the ADC config_reg write port.
// Frames of exactly ADDR_W+DATA_W bits produce one write; any other length pulses frame_err.
module cfg_serial_loader #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              sclk,
  input  logic              sdi,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned FRAME_BITS = ADDR_W + DATA_W;
  localparam logic [4:0]  FRAME_CNT  = 5'(FRAME_BITS);
  localparam logic [4:0]  CNT_MAX    = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   sdi_s;
  logic                   cs_d;
  logic                   sclk_d;
  logic                   cs_fall_q;
  logic                   cs_rise_q;
  logic                   sclk_rise_q;
  logic                   sdi_q;
  logic [FRAME_BITS-1:0]  shift;
  logic [4:0]             count;
  state_t                 state;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      sdi_sync  <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
    end
  end

  // Edge pulses are registered (sdi travels alongside) so that the FSM's
  // registered write lands SYNC_STAGES+2 edges after cs_n is first sampled high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_d        <= 1'b1;
      sclk_d      <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sdi_q       <= 1'b0;
    end else begin
      cs_d        <= cs_s;
      sclk_d      <= sclk_s;
      cs_fall_q   <= cs_d & ~cs_s;
      cs_rise_q   <= ~cs_d & cs_s;
      sclk_rise_q <= sclk_s & ~sclk_d;
      sdi_q       <= sdi_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift     <= '0;
      count     <= '0;
      write     <= 1'b0;
      address   <= '0;
      data_in   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      write     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (cs_fall_q) begin
            state <= SHIFT;
            busy  <= 1'b1;
            count <= '0;
            shift <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise_q) begin
            busy <= 1'b0;
            if (count == FRAME_CNT) begin
              state   <= COMMIT;
              write   <= 1'b1;
              address <= shift[FRAME_BITS-1 -: ADDR_W];
              data_in <= shift[DATA_W-1:0];
            end else begin
              state     <= IDLE;
              frame_err <= 1'b1;
            end
          end else if (sclk_rise_q) begin
            shift <= {shift[FRAME_BITS-2:0], sdi_q};
            if (count != CNT_MAX) begin
              count <= count + 5'd1;
            end
          end
        end
        COMMIT: begin
          // A new frame may start while the write strobe is still high.
          if (cs_fall_q) begin
            state <= SHIFT;
            busy  <= 1'b1;
            count <= '0;
            shift <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_serial_loader.sv
// Directed bench for cfg_serial_loader: table of frames plus hand-written
// back-to-back, commit-overlap, reset-mid-frame and idle-sclk sequences.
module tb_cfg_serial_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n;
  logic        sclk;
  logic        sdi;
  logic        write;
  logic [2:0]  address;
  logic [15:0] data_in;
  logic        busy;
  logic        frame_err;

  cfg_serial_loader #(
    .ADDR_W      (3),
    .DATA_W      (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .sdi       (sdi),
    .write     (write),
    .address   (address),
    .data_in   (data_in),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int          wr_cnt    = 0;
  int          err_cnt   = 0;
  int          overlap   = 0;
  int          busy_hits = 0;
  int          last_w    = 0;
  int          last_e    = 0;
  logic [18:0] wq[$];

  always @(negedge clk) begin
    if (write) begin
      wr_cnt++;
      last_w = cyc;
      wq.push_back({address, data_in});
    end
    if (frame_err) begin
      err_cnt++;
      last_e = cyc;
    end
    if (write && frame_err) overlap++;
    if (busy) busy_hits++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic shift_bits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = bits[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] bits, input int n,
                            output logic busy_mid, output int p);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    shift_bits(bits, n);
    busy_mid = busy;
    cs_n = 1'b1;
    p = cyc;
  endtask

  typedef struct {
    logic [63:0] bits;
    int          n;
    int          exp_w;
    int          exp_e;
    logic [2:0]  exp_a;
    logic [15:0] exp_d;
  } vec_t;

  vec_t v[8];

  initial begin
    logic        bm;
    int          p;
    int          w0;
    int          e0;
    int          b0;
    logic [18:0] q0;
    logic [18:0] q1;

    v[0] = '{64'({3'b001, 16'h0001}), 19, 1, 0, 3'd1, 16'h0001};
    v[1] = '{64'({3'b011, 16'h5A3C}), 19, 1, 0, 3'd3, 16'h5A3C};
    v[2] = '{64'h2AAAA,               18, 0, 1, 3'd3, 16'h5A3C};
    v[3] = '{64'hFFFFF,               20, 0, 1, 3'd3, 16'h5A3C};
    v[4] = '{64'h0,                    0, 0, 1, 3'd3, 16'h5A3C};
    v[5] = '{64'hF0F0F0F0F0,          40, 0, 1, 3'd3, 16'h5A3C};
    v[6] = '{64'h7FFFFFFFFFFFF,       51, 0, 1, 3'd3, 16'h5A3C};
    v[7] = '{64'({3'b110, 16'h8001}), 19, 1, 0, 3'd6, 16'h8001};

    reset = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    sdi   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_write", write, 0);
    check("rst_address", address, 0);
    check("rst_data_in", data_in, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      w0 = wr_cnt;
      e0 = err_cnt;
      send_frame(v[i].bits, v[i].n, bm, p);
      repeat (12) @(negedge clk);
      check($sformatf("v%0d_busy", i), bm, 1);
      check($sformatf("v%0d_writes", i), wr_cnt - w0, v[i].exp_w);
      check($sformatf("v%0d_errs", i), err_cnt - e0, v[i].exp_e);
      check($sformatf("v%0d_address", i), address, v[i].exp_a);
      check($sformatf("v%0d_data_in", i), data_in, v[i].exp_d);
      check($sformatf("v%0d_latency", i), (v[i].exp_w != 0 ? last_w : last_e) - p, 4);
    end

    // back-to-back frames, cs_n high for 4 clocks between them
    wq.delete();
    w0 = wr_cnt;
    e0 = err_cnt;
    send_frame(64'({3'b101, 16'hA5C3}), 19, bm, p);
    repeat (4) @(negedge clk);
    send_frame(64'({3'b010, 16'h1234}), 19, bm, p);
    repeat (12) @(negedge clk);
    q0 = (wq.size() > 0) ? wq[0] : '1;
    q1 = (wq.size() > 1) ? wq[1] : '1;
    check("b2b_writes", wr_cnt - w0, 2);
    check("b2b_errs", err_cnt - e0, 0);
    check("b2b_first", q0, {3'b101, 16'hA5C3});
    check("b2b_second", q1, {3'b010, 16'h1234});

    // cs_n high for a single clock: next frame starts while COMMIT is active
    wq.delete();
    w0 = wr_cnt;
    e0 = err_cnt;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    shift_bits(64'({3'b100, 16'h0F0F}), 19);
    cs_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    shift_bits(64'({3'b001, 16'hBEEF}), 19);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    q0 = (wq.size() > 0) ? wq[0] : '1;
    q1 = (wq.size() > 1) ? wq[1] : '1;
    check("overlap_writes", wr_cnt - w0, 2);
    check("overlap_errs", err_cnt - e0, 0);
    check("overlap_first", q0, {3'b100, 16'h0F0F});
    check("overlap_second", q1, {3'b001, 16'hBEEF});

    // reset after 10 bits of a frame
    w0 = wr_cnt;
    e0 = err_cnt;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    shift_bits(64'h2C5, 10);
    reset = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    #1;
    check("midrst_write", write, 0);
    check("midrst_address", address, 0);
    check("midrst_data_in", data_in, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_err", frame_err, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_writes", wr_cnt - w0, 0);
    check("midrst_errs", err_cnt - e0, 0);
    send_frame(64'({3'b111, 16'hFFFF}), 19, bm, p);
    repeat (12) @(negedge clk);
    check("postrst_writes", wr_cnt - w0, 1);
    check("postrst_errs", err_cnt - e0, 0);
    check("postrst_address", address, 3'b111);
    check("postrst_data_in", data_in, 16'hFFFF);

    // sclk activity with cs_n high
    w0 = wr_cnt;
    e0 = err_cnt;
    b0 = busy_hits;
    for (int i = 0; i < 19; i++) begin
      sdi = i[0];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (12) @(negedge clk);
    check("idle_sclk_writes", wr_cnt - w0, 0);
    check("idle_sclk_errs", err_cnt - e0, 0);
    check("idle_sclk_busy", busy_hits - b0, 0);
    check("write_err_exclusive", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
